dru_load_ctrl: RTL and testbench
================================

// Module: dru_load_ctrl
// PURPOSE
//  Upstream sequencer for the data register unit (DRU). Accepts one load/clear command at a time.
//  Issues memory read requests or waits for the feedback bus. Drives the DRU's one-hot load
//  strobes (up/lo 32-bit, 64-bit reg1/reg2) and its clear strobe, timed so the DRU captures
//  stable mem_data/fb_data. Sits between the NPU command decoder and the DRU.
// PARAMETERS
//  ADDR_W       16   memory word address width
//  TIMEOUT_CYC  255  max wait cycles for mem_rd_ack/fb_valid (used only with DRU_LDC_TIMEOUT_EN)
// PORTS
//  sys_clk          in   1       single clock, all logic on posedge
//  sys_rst_n        in   1       synchronous, active-low reset
//  cmd_valid        in   1       command present
//  cmd_ready        out  1       command accepted when cmd_valid & cmd_ready
//  cmd_op           in   3       0 CLR, 1 LD_UP, 2 LD_LO, 3 LD_UPLO, 4 LD_FB1, 5 LD_FB2, 6-7 reserved
//  cmd_addr         in   ADDR_W  memory word address (mem ops only)
//  mem_rd_req       out  1       read request, held until ack
//  mem_rd_addr      out  ADDR_W  read address, stable while mem_rd_req=1
//  mem_rd_ack       in   1       mem_data valid this cycle; memory holds it until next mem_rd_req
//  fb_valid         in   1       fb_data valid this cycle; held until next fb op
//  up_reg32_enable  out  1       DRU upper 32-bit load strobe
//  lo_reg32_enable  out  1       DRU lower 32-bit load strobe
//  reg64_enable1    out  1       DRU 64-bit reg1 load strobe
//  reg64_enable2    out  1       DRU 64-bit reg2 load strobe
//  clear_data_regs  out  1       DRU clear strobe
//  busy             out  1       high in any state except IDLE
//  done             out  1       one-cycle pulse at command completion
//  err              out  1       one-cycle pulse with done on timeout (tied 0 without macro)
// BEHAVIOUR
//  - Reset (sys_rst_n=0 at posedge): state IDLE, op/addr regs and all outputs 0 except cmd_ready=1.
//    Reset mid-operation abandons the in-flight read; no strobe is emitted.
//  - All outputs are Moore-decoded from registered state; at most one DRU strobe high in any cycle.
//  - FSM states: IDLE, REQ, FBW, LOAD, CLR, DONE.
//  - IDLE: cmd_ready=1. On accept, latch op/addr and go to:
//      CLR for op 0; REQ for ops 1-3; FBW for ops 4-5; DONE (no strobe, err=0) for ops 6-7.
//  - REQ: mem_rd_req=1, mem_rd_addr=latched addr. On mem_rd_ack go to LOAD.
//  - FBW: wait for fb_valid, then go to LOAD.
//  - LOAD: exactly one strobe, for one cycle:
//      LD_UP/LD_UPLO phase 0 -> up_reg32_enable; LD_LO/LD_UPLO phase 1 -> lo_reg32_enable;
//      FB1 -> reg64_enable1; FB2 -> reg64_enable2.
//    LD_UPLO phase 0: addr <= addr+1 (wraps mod 2^ADDR_W), phase <= 1, go to REQ.
//    All other cases go to DONE.
//  - CLR: clear_data_regs=1 for one cycle, then DONE.
//  - DONE: done=1 for one cycle, then IDLE.
//  - Latency, ack in first REQ cycle: accept@0, REQ@1, strobe@2, done@3.
//    LD_UPLO gives done@5. CLR gives clear@1, done@2.
//  - cmd_valid while busy is ignored (cmd_ready=0). mem_rd_ack outside REQ and fb_valid outside
//    FBW are ignored.
// CONFIGURATION
//  DRU_LDC_TIMEOUT_EN defined:
//    - A wait counter clears on entering REQ/FBW and increments each cycle spent there.
//    - If it reaches TIMEOUT_CYC with no ack/valid: go to DONE with err=1, no strobe, mem_rd_req drops.
//    - An ack in the same cycle the count hits the limit wins: normal LOAD.
//  DRU_LDC_TIMEOUT_EN undefined: no counter; waits forever; err tied 0.
// STRUCTURE
//  - dru_pkg: cmd_op encodings (DRU_OP_*), FSM state typedef/localparams, phase encoding.
//  - Sub-module dru_ldc_watchdog (counter + limit compare), instantiated only under
//    DRU_LDC_TIMEOUT_EN.
// TESTING
//  1. LD_UP addr=0x0010, ack on 1st REQ cycle -> mem_rd_addr=0x0010;
//     up_reg32_enable pulse @2; done @3; other strobes 0.
//  2. LD_UPLO addr=0xFFFF, ack delayed 3 cycles per read -> reads 0xFFFF then 0x0000 (wrap);
//     up strobe, then lo strobe; single done.
//  3. LD_FB2, fb_valid after 5 cycles -> reg64_enable2 pulse one cycle after fb_valid; done next;
//     mem_rd_req stays 0.
//  4. CLR during busy, then CLR from IDLE -> first ignored (cmd_ready=0);
//     second gives clear_data_regs @1, done @2.
//  5. sys_rst_n=0 while in REQ -> next cycle IDLE, mem_rd_req=0, no strobe,
//     later ack ignored; reserved op 7 -> done only.
//  6. (DRU_LDC_TIMEOUT_EN, TIMEOUT_CYC=8) LD_LO, never ack -> err+done pulse after 8 REQ cycles,
//     lo_reg32_enable never asserted.

Source files
------------

// File: rtl/dru_pkg.sv
// Shared encodings for the DRU load controller: command opcodes, FSM states and UPLO phase.
package dru_pkg;

  localparam logic [2:0] DRU_OP_CLR     = 3'd0;
  localparam logic [2:0] DRU_OP_LD_UP   = 3'd1;
  localparam logic [2:0] DRU_OP_LD_LO   = 3'd2;
  localparam logic [2:0] DRU_OP_LD_UPLO = 3'd3;
  localparam logic [2:0] DRU_OP_LD_FB1  = 3'd4;
  localparam logic [2:0] DRU_OP_LD_FB2  = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFbw,
    StLoad,
    StClr,
    StDone
  } dru_state_e;

  typedef enum logic {
    PhaseFirst,
    PhaseSecond
  } dru_phase_e;

  function automatic logic is_mem_op(logic [2:0] op);
    return (op == DRU_OP_LD_UP) || (op == DRU_OP_LD_LO) || (op == DRU_OP_LD_UPLO);
  endfunction

  function automatic logic is_fb_op(logic [2:0] op);
    return (op == DRU_OP_LD_FB1) || (op == DRU_OP_LD_FB2);
  endfunction

endpackage

// File: rtl/dru_ldc_watchdog.sv
// Wait-cycle counter for the DRU load controller; only built with DRU_LDC_TIMEOUT_EN.
module dru_ldc_watchdog #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Limit < 2) ? 1 : $clog2(Limit + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q;

  // Held at zero outside a wait state, so each entry into REQ/FBW starts a fresh count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !active_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LastCnt) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expired_o = active_i && (cnt_q == LastCnt);

endmodule

// File: rtl/dru_load_ctrl.sv
// Load/clear sequencer in front of the DRU. Optional wait timeout enabled by DRU_LDC_TIMEOUT_EN.
module dru_load_ctrl
  import dru_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              fb_valid,
  output logic              up_reg32_enable,
  output logic              lo_reg32_enable,
  output logic              reg64_enable1,
  output logic              reg64_enable2,
  output logic              clear_data_regs,
  output logic              busy,
  output logic              done,
  output logic              err
);

  dru_state_e        state_q, state_d;
  dru_phase_e        phase_q, phase_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_d;
  logic              wait_expired;

`ifdef DRU_LDC_TIMEOUT_EN
  dru_ldc_watchdog #(
    .Limit (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .active_i  ((state_q == StReq) || (state_q == StFbw)),
    .expired_o (wait_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign wait_expired       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    op_d    = op_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          phase_d = PhaseFirst;
          if (cmd_op == DRU_OP_CLR)  state_d = StClr;
          else if (is_mem_op(cmd_op)) state_d = StReq;
          else if (is_fb_op(cmd_op))  state_d = StFbw;
          else                        state_d = StDone;
        end
      end
      StReq: begin
        // An ack arriving in the expiry cycle still wins.
        if (mem_rd_ack) begin
          state_d = StLoad;
        end else if (wait_expired) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StFbw: begin
        if (fb_valid) begin
          state_d = StLoad;
        end else if (wait_expired) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StLoad: begin
        if (op_q == DRU_OP_LD_UPLO && phase_q == PhaseFirst) begin
          addr_d  = addr_q + ADDR_W'(1);
          phase_d = PhaseSecond;
          state_d = StReq;
        end else begin
          state_d = StDone;
        end
      end
      StClr:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q         <= StIdle;
      phase_q         <= PhaseFirst;
      op_q            <= '0;
      addr_q          <= '0;
      cmd_ready       <= 1'b1;
      mem_rd_req      <= 1'b0;
      up_reg32_enable <= 1'b0;
      lo_reg32_enable <= 1'b0;
      reg64_enable1   <= 1'b0;
      reg64_enable2   <= 1'b0;
      clear_data_regs <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      op_q            <= op_d;
      addr_q          <= addr_d;
      cmd_ready       <= (state_d == StIdle);
      mem_rd_req      <= (state_d == StReq);
      up_reg32_enable <= (state_d == StLoad) &&
                         ((op_d == DRU_OP_LD_UP) ||
                          (op_d == DRU_OP_LD_UPLO && phase_d == PhaseFirst));
      lo_reg32_enable <= (state_d == StLoad) &&
                         ((op_d == DRU_OP_LD_LO) ||
                          (op_d == DRU_OP_LD_UPLO && phase_d == PhaseSecond));
      reg64_enable1   <= (state_d == StLoad) && (op_d == DRU_OP_LD_FB1);
      reg64_enable2   <= (state_d == StLoad) && (op_d == DRU_OP_LD_FB2);
      clear_data_regs <= (state_d == StClr);
      busy            <= (state_d != StIdle);
      done            <= (state_d == StDone);
      err             <= err_d;
    end
  end

  assign mem_rd_addr = addr_q;

endmodule

// File: tb/tb_dru_load_ctrl.sv
// Bench for dru_load_ctrl: directed scenarios plus random commands against a cycle-plan model.
module tb_dru_load_ctrl;

  localparam logic [9:0] O_READY = 10'b10_0000_0000;
  localparam logic [9:0] O_BUSY  = 10'b01_0000_0000;
  localparam logic [9:0] O_REQ   = 10'b00_1000_0000;
  localparam logic [9:0] O_UP    = 10'b00_0100_0000;
  localparam logic [9:0] O_LO    = 10'b00_0010_0000;
  localparam logic [9:0] O_R1    = 10'b00_0001_0000;
  localparam logic [9:0] O_R2    = 10'b00_0000_1000;
  localparam logic [9:0] O_CLR   = 10'b00_0000_0100;
  localparam logic [9:0] O_DONE  = 10'b00_0000_0010;
  localparam logic [9:0] O_ERR   = 10'b00_0000_0001;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic        mem_rd_req;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_ack;
  logic        fb_valid;
  logic        up_reg32_enable;
  logic        lo_reg32_enable;
  logic        reg64_enable1;
  logic        reg64_enable2;
  logic        clear_data_regs;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  // One entry per cycle after acceptance: what the DRU interface must show, and what to drive.
  typedef struct {
    logic [9:0]  outs;
    logic [15:0] addr;
    bit          ack_fix;
    bit          ack_val;
    bit          fb_fix;
    bit          fb_val;
  } exp_t;
  exp_t exp_q[$];

  dru_load_ctrl #(
    .ADDR_W      (16),
    .TIMEOUT_CYC (8)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_addr        (cmd_addr),
    .mem_rd_req      (mem_rd_req),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_ack      (mem_rd_ack),
    .fb_valid        (fb_valid),
    .up_reg32_enable (up_reg32_enable),
    .lo_reg32_enable (lo_reg32_enable),
    .reg64_enable1   (reg64_enable1),
    .reg64_enable2   (reg64_enable2),
    .clear_data_regs (clear_data_regs),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end

  task automatic check_outs(input string tag, input logic [9:0] exp);
    logic [9:0] got;
    got = {cmd_ready, busy, mem_rd_req, up_reg32_enable, lo_reg32_enable, reg64_enable1,
           reg64_enable2, clear_data_regs, done, err};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_addr(input string tag, input logic [15:0] exp);
    checks++;
    assert (mem_rd_addr === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, mem_rd_addr, exp);
    end
  endtask

  task automatic push(input logic [9:0] o, input logic [15:0] a, input bit af, input bit av,
                      input bit ff, input bit fv);
    exp_t e;
    e.outs = o;
    e.addr = a;
    e.ack_fix = af;
    e.ack_val = av;
    e.fb_fix = ff;
    e.fb_val = fv;
    exp_q.push_back(e);
  endtask

  // d0/d1: cycles of waiting before ack (or fb_valid) for the first/second read.
  task automatic build_plan(input logic [2:0] op, input logic [15:0] a, input int d0,
                            input int d1);
    logic [15:0] ra;
    int          nreads;
    int          d;
    ra = a;
    case (op)
      3'd0: begin
        push(O_BUSY | O_CLR, 16'h0, 0, 0, 0, 0);
        push(O_BUSY | O_DONE, 16'h0, 0, 0, 0, 0);
      end
      3'd1, 3'd2, 3'd3: begin
        nreads = (op == 3'd3) ? 2 : 1;
        for (int r = 0; r < nreads; r++) begin
          d = (r == 0) ? d0 : d1;
          for (int k = 0; k <= d; k++) push(O_BUSY | O_REQ, ra, 1, (k == d), 0, 0);
          push(O_BUSY | ((op == 3'd1 || (op == 3'd3 && r == 0)) ? O_UP : O_LO), 16'h0,
               0, 0, 0, 0);
          ra = ra + 16'd1;
        end
        push(O_BUSY | O_DONE, 16'h0, 0, 0, 0, 0);
      end
      3'd4, 3'd5: begin
        for (int k = 0; k <= d0; k++) push(O_BUSY, 16'h0, 0, 0, 1, (k == d0));
        push(O_BUSY | ((op == 3'd4) ? O_R1 : O_R2), 16'h0, 0, 0, 0, 0);
        push(O_BUSY | O_DONE, 16'h0, 0, 0, 0, 0);
      end
      default: push(O_BUSY | O_DONE, 16'h0, 0, 0, 0, 0);
    endcase
  endtask

  // Called at a negedge with the DUT idle; walks the plan, injecting noise on don't-care inputs.
  task automatic run_plan(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input bit noisy);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    mem_rd_ack = noisy ? 1'($urandom) : 1'b0;
    fb_valid = noisy ? 1'($urandom) : 1'b0;
    check_outs({tag, "/accept"}, O_READY);
    @(posedge sys_clk);
    @(negedge sys_clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      check_outs($sformatf("%s/cyc%0d", tag, i), e.outs);
      if (e.outs & O_REQ) check_addr($sformatf("%s/addr%0d", tag, i), e.addr);
      mem_rd_ack = e.ack_fix ? e.ack_val : (noisy ? 1'($urandom) : 1'b0);
      fb_valid = e.fb_fix ? e.fb_val : (noisy ? 1'($urandom) : 1'b0);
      cmd_valid = noisy ? 1'($urandom) : 1'b0;
      cmd_op = 3'($urandom);
      cmd_addr = 16'($urandom);
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    cmd_valid = 1'b0;
    mem_rd_ack = 1'b0;
    fb_valid = 1'b0;
    check_outs({tag, "/idle"}, O_READY);
    exp_q.delete();
  endtask

  initial begin
    logic [2:0]  rop;
    logic [15:0] raddr;
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_addr = 16'h0;
    mem_rd_ack = 1'b0;
    fb_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_outs("reset", O_READY);
    check_addr("reset_addr", 16'h0000);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Single upper load, ack in first REQ cycle.
    build_plan(3'd1, 16'h0010, 0, 0);
    run_plan("ld_up", 3'd1, 16'h0010, 1'b0);

    // Paired load across the address wrap, ack after 3 cycles per read.
    build_plan(3'd3, 16'hFFFF, 3, 3);
    run_plan("ld_uplo_wrap", 3'd3, 16'hFFFF, 1'b0);

    // Feedback load with fb_valid after 5 waiting cycles.
    build_plan(3'd5, 16'h1234, 5, 0);
    run_plan("ld_fb2", 3'd5, 16'h1234, 1'b0);

    // CLR offered while busy must be ignored; a later CLR from idle clears.
    build_plan(3'd2, 16'h00A0, 2, 0);
    cmd_valid = 1'b1;
    cmd_op = 3'd2;
    cmd_addr = 16'h00A0;
    check_outs("busy_clr/accept", O_READY);
    @(posedge sys_clk);
    @(negedge sys_clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_outs($sformatf("busy_clr/cyc%0d", i), exp_q[i].outs);
      cmd_valid = 1'b1;
      cmd_op = 3'd0;
      mem_rd_ack = exp_q[i].ack_val;
      @(posedge sys_clk);
      @(negedge sys_clk);
    end
    cmd_valid = 1'b0;
    mem_rd_ack = 1'b0;
    check_outs("busy_clr/idle", O_READY);
    exp_q.delete();
    build_plan(3'd0, 16'h0, 0, 0);
    run_plan("clr", 3'd0, 16'h0, 1'b0);

    // Reset while a read is outstanding; a late ack must not restart anything.
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_addr = 16'h0BEE;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    check_outs("rst_mid/req", O_BUSY | O_REQ);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    check_outs("rst_mid/after", O_READY);
    check_addr("rst_mid/addr", 16'h0000);
    mem_rd_ack = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    mem_rd_ack = 1'b0;
    check_outs("rst_mid/late_ack", O_READY);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_outs("rst_mid/late_ack2", O_READY);

    build_plan(3'd7, 16'h5555, 0, 0);
    run_plan("reserved7", 3'd7, 16'h5555, 1'b0);

`ifdef DRU_LDC_TIMEOUT_EN
    // Never acknowledged: 8 REQ cycles then done+err, no strobe.
    for (int k = 0; k < 8; k++) push(O_BUSY | O_REQ, 16'h0040, 1, 0, 0, 0);
    push(O_BUSY | O_DONE | O_ERR, 16'h0, 0, 0, 0, 0);
    run_plan("timeout_lo", 3'd2, 16'h0040, 1'b0);
`endif

    // Random commands with noise on every input the controller must ignore.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      raddr = 16'($urandom);
      build_plan(rop, raddr, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      run_plan($sformatf("rnd%0d_op%0d", n, rop), rop, raddr, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
